// File: rtl/lbm_pkg.sv
// Shared types and defaults for the LBM lattice sweep controller.
//   sweep_state_t : sequencer state encoding
//   *_DEF         : default lattice / run / pipeline sizing
//   coord_to_addr : (x, y) -> linear raster address y*gx + x
package lbm_pkg;

  localparam int unsigned GRID_X_DEF     = 16;
  localparam int unsigned GRID_Y_DEF     = 16;
  localparam int unsigned MAX_TIME_DEF   = 100;
  localparam int unsigned PIPE_DEPTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    SWAP  = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } sweep_state_t;

  function automatic int unsigned coord_to_addr(input int unsigned x,
                                                input int unsigned y,
                                                input int unsigned gx);
    return (y * gx) + x;
  endfunction

endpackage

// File: rtl/lbm_cell_counter.sv
// Raster x/y cell counter with wrap, last-cell flag and edge decode.
//   clk, rst     : clock, synchronous active-high reset
//   i_clear      : return to cell (0,0)
//   i_step       : advance one cell in raster order
//   o_x/o_y      : current column/row
//   o_addr       : current linear address
//   o_last_c     : current cell is (GRID_X-1, GRID_Y-1)
//   o_bnd_nxt_c  : the cell loaded at the next edge lies on the outer edge
module lbm_cell_counter
  import lbm_pkg::*;
#(
  parameter int unsigned GRID_X        = GRID_X_DEF,
  parameter int unsigned GRID_Y        = GRID_Y_DEF,
  parameter int unsigned X_WIDTH       = 4,
  parameter int unsigned Y_WIDTH       = 4,
  parameter int unsigned ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_step,
  output logic [X_WIDTH-1:0]       o_x,
  output logic [Y_WIDTH-1:0]       o_y,
  output logic [ADDRESS_WIDTH-1:0] o_addr,
  output logic                     o_last_c,
  output logic                     o_bnd_nxt_c
);

  logic [X_WIDTH-1:0]       r_x, w_x_nxt;
  logic [Y_WIDTH-1:0]       r_y, w_y_nxt;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic                     w_x_end, w_y_end;

  assign w_x_end  = (r_x == X_WIDTH'(GRID_X - 1));
  assign w_y_end  = (r_y == Y_WIDTH'(GRID_Y - 1));
  assign o_last_c = w_x_end & w_y_end;

  // Next coordinate: clear wins, otherwise step with x-then-y wrap
  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (i_clear) begin
      w_x_nxt = '0;
      w_y_nxt = '0;
    end else if (i_step) begin
      if (w_x_end) begin
        w_x_nxt = '0;
        w_y_nxt = w_y_end ? '0 : r_y + Y_WIDTH'(1);
      end else begin
        w_x_nxt = r_x + X_WIDTH'(1);
      end
    end
  end

  assign o_bnd_nxt_c = (w_x_nxt == '0) || (w_x_nxt == X_WIDTH'(GRID_X - 1)) ||
                       (w_y_nxt == '0) || (w_y_nxt == Y_WIDTH'(GRID_Y - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
    end else begin
      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
      r_addr <= ADDRESS_WIDTH'(coord_to_addr(32'(w_x_nxt), 32'(w_y_nxt), GRID_X));
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_addr = r_addr;

endmodule

// File: rtl/lbm_sweep_ctrl.sv
// Time-step / sweep sequencer for the LBM lattice engine.
//   CLOCK_50, RESET    : clock, synchronous active-high reset
//   START, STEP_MODE,
//   ADVANCE            : run control (start pulse, pause-per-step, release)
//   rd_valid/rd_ready  : cell request handshake to the collide/stream pipe
//   rd_addr, cell_x,
//   cell_y, is_boundary: request payload
//   rd_bank            : source bank this step (destination is ~rd_bank)
//   wr_done            : one cell retired by the pipeline
//   time_count, busy,
//   step_done, FINISHED,
//   err_underflow      : status
module lbm_sweep_ctrl
  import lbm_pkg::*;
#(
  parameter int unsigned GRID_X           = GRID_X_DEF,
  parameter int unsigned GRID_Y           = GRID_Y_DEF,
  parameter int unsigned MAX_TIME         = MAX_TIME_DEF,
  parameter int unsigned TIME_COUNT_WIDTH = ($clog2(MAX_TIME + 1) > 0) ? $clog2(MAX_TIME + 1) : 1,
  parameter int unsigned ADDRESS_WIDTH    = ($clog2(GRID_X * GRID_Y) > 0) ? $clog2(GRID_X * GRID_Y) : 1,
  parameter int unsigned PIPE_DEPTH       = PIPE_DEPTH_DEF,
  parameter int unsigned X_WIDTH          = (GRID_X > 1) ? $clog2(GRID_X) : 1,
  parameter int unsigned Y_WIDTH          = (GRID_Y > 1) ? $clog2(GRID_Y) : 1
) (
  input  logic                        CLOCK_50,
  input  logic                        RESET,
  input  logic                        START,
  input  logic                        STEP_MODE,
  input  logic                        ADVANCE,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [ADDRESS_WIDTH-1:0]    rd_addr,
  output logic [X_WIDTH-1:0]          cell_x,
  output logic [Y_WIDTH-1:0]          cell_y,
  output logic                        is_boundary,
  output logic                        rd_bank,
  input  logic                        wr_done,
  output logic [TIME_COUNT_WIDTH-1:0] time_count,
  output logic                        busy,
  output logic                        step_done,
  output logic                        FINISHED,
  output logic                        err_underflow
);

  localparam int unsigned IW = $clog2(PIPE_DEPTH + 1);

  sweep_state_t                r_state, w_state_nxt;
  logic [IW-1:0]               r_inflight, w_inflight_nxt;
  logic [TIME_COUNT_WIDTH-1:0] r_time, w_time_inc;
  logic                        r_rd_valid, r_is_boundary, r_bank, r_busy;
  logic                        r_step_done, r_finished, r_err;
  logic                        w_xfer, w_retire, w_underflow, w_clear, w_swap;
  logic                        w_last_c, w_bnd_nxt_c, w_rd_valid_nxt;

  assign w_xfer      = r_rd_valid & rd_ready;
  assign w_retire    = wr_done & (r_inflight != '0);
  assign w_underflow = wr_done & (r_inflight == '0);
  assign w_time_inc  = r_time + TIME_COUNT_WIDTH'(1);

  lbm_cell_counter #(
    .GRID_X       (GRID_X),
    .GRID_Y       (GRID_Y),
    .X_WIDTH      (X_WIDTH),
    .Y_WIDTH      (Y_WIDTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_cell_counter (
    .clk        (CLOCK_50),
    .rst        (RESET),
    .i_clear    (w_clear),
    .i_step     (w_xfer),
    .o_x        (cell_x),
    .o_y        (cell_y),
    .o_addr     (rd_addr),
    .o_last_c   (w_last_c),
    .o_bnd_nxt_c(w_bnd_nxt_c)
  );

  // Sequencer next-state
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_swap      = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (START) begin
          w_clear     = 1'b1;
          w_state_nxt = (MAX_TIME == 0) ? DONE : ISSUE;
        end
      end
      HOLD: begin
        if (START) begin
          w_clear     = 1'b1;
          w_state_nxt = (MAX_TIME == 0) ? DONE : ISSUE;
        end else if (ADVANCE) begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (w_xfer && w_last_c) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (r_inflight == '0) w_state_nxt = SWAP;
      end
      SWAP: begin
        w_swap = 1'b1;
        if (w_time_inc == TIME_COUNT_WIDTH'(MAX_TIME)) w_state_nxt = DONE;
        else if (STEP_MODE)                            w_state_nxt = HOLD;
        else                                           w_state_nxt = ISSUE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // In-flight tracking; a retire without anything in flight is dropped
  always_comb begin
    w_inflight_nxt = r_inflight;
    if (w_clear)                    w_inflight_nxt = '0;
    else if (w_xfer && !w_retire)   w_inflight_nxt = r_inflight + IW'(1);
    else if (!w_xfer && w_retire)   w_inflight_nxt = r_inflight - IW'(1);
  end

  assign w_rd_valid_nxt = (w_state_nxt == ISSUE) && (w_inflight_nxt < IW'(PIPE_DEPTH));

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_state       <= IDLE;
      r_inflight    <= '0;
      r_time        <= '0;
      r_rd_valid    <= 1'b0;
      r_is_boundary <= 1'b0;
      r_bank        <= 1'b0;
      r_busy        <= 1'b0;
      r_step_done   <= 1'b0;
      r_finished    <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_inflight    <= w_inflight_nxt;
      r_rd_valid    <= w_rd_valid_nxt;
      // Edge tag only qualifies a live request
      r_is_boundary <= w_rd_valid_nxt & w_bnd_nxt_c;
      r_busy        <= (w_state_nxt == ISSUE) || (w_state_nxt == DRAIN) ||
                       (w_state_nxt == SWAP);
      r_step_done   <= (w_state_nxt == SWAP);
      if (w_clear) begin
        r_bank <= 1'b0;
        r_time <= '0;
      end else if (w_swap) begin
        r_bank <= ~r_bank;
        r_time <= w_time_inc;
      end
      if (w_state_nxt == DONE) r_finished <= 1'b1;
      else if (w_clear)        r_finished <= 1'b0;
      if (w_underflow)         r_err <= 1'b1;
      else if (w_clear)        r_err <= 1'b0;
    end
  end

  assign rd_valid      = r_rd_valid;
  assign is_boundary   = r_is_boundary;
  assign rd_bank       = r_bank;
  assign time_count    = r_time;
  assign busy          = r_busy;
  assign step_done     = r_step_done;
  assign FINISHED      = r_finished;
  assign err_underflow = r_err;

endmodule

// File: tb/tb_lbm_sweep_ctrl.sv
// Directed self-checking bench for lbm_sweep_ctrl on a 4x2 lattice,
// three time steps, two-deep pipeline.
module tb_lbm_sweep_ctrl;

  logic       clk, rst, start, step_mode, advance, rd_ready, wr_done;
  logic       man_wr, echo_wr, echo_en, echo_d0, echo_d1;
  logic       rd_valid, is_boundary, rd_bank, busy, step_done, finished, err_underflow;
  logic [2:0] rd_addr;
  logic [1:0] cell_x;
  logic [0:0] cell_y;
  logic [1:0] time_count;

  int checks = 0;
  int errors = 0;
  int nx, steps, cnt;

  lbm_sweep_ctrl #(
    .GRID_X    (4),
    .GRID_Y    (2),
    .MAX_TIME  (3),
    .PIPE_DEPTH(2)
  ) dut (
    .CLOCK_50     (clk),
    .RESET        (rst),
    .START        (start),
    .STEP_MODE    (step_mode),
    .ADVANCE      (advance),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_addr      (rd_addr),
    .cell_x       (cell_x),
    .cell_y       (cell_y),
    .is_boundary  (is_boundary),
    .rd_bank      (rd_bank),
    .wr_done      (wr_done),
    .time_count   (time_count),
    .busy         (busy),
    .step_done    (step_done),
    .FINISHED     (finished),
    .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pipeline stand-in: retire each accepted cell two cycles later
  always @(negedge clk) begin
    if (echo_en) begin
      echo_wr = echo_d1;
      echo_d1 = echo_d0;
      echo_d0 = rd_valid & rd_ready;
    end else begin
      echo_wr = 1'b0;
      echo_d1 = 1'b0;
      echo_d0 = 1'b0;
    end
  end

  assign wr_done = man_wr | echo_wr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, 32'({rd_valid, rd_addr, cell_x, cell_y, is_boundary, rd_bank,
                  time_count, busy, step_done, finished, err_underflow}), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; step_mode = 1'b0; advance = 1'b0;
    rd_ready = 1'b0; man_wr = 1'b0; echo_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_zero("reset_state");

    // wr_done with nothing in flight
    man_wr = 1'b1;
    @(negedge clk);
    man_wr = 1'b0;
    chk("uflow_idle", 32'(err_underflow), 1);
    chk("uflow_idle_busy", 32'(busy), 0);

    // Full run: three sweeps of eight cells
    rd_ready = 1'b1;
    echo_en  = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_clears_uflow", 32'(err_underflow), 0);
    chk("start_latency_valid", 32'(rd_valid), 1);
    chk("start_addr", 32'(rd_addr), 0);
    chk("start_busy", 32'(busy), 1);
    chk("start_corner_bnd", 32'(is_boundary), 1);
    nx = 0;
    steps = 0;
    for (int c = 0; c < 600; c++) begin
      if (finished) break;
      if (step_done) steps++;
      if (rd_valid && rd_ready) begin
        chk("run_addr", 32'(rd_addr), 32'(nx % 8));
        chk("run_bank", 32'(rd_bank), 32'((nx / 8) % 2));
        nx++;
      end
      @(negedge clk);
    end
    chk("run_finished", 32'(finished), 1);
    chk("run_time", 32'(time_count), 3);
    chk("run_step_pulses", 32'(steps), 3);
    chk("run_cells", 32'(nx), 24);
    chk("run_done_busy", 32'(busy), 0);
    chk("run_final_bank", 32'(rd_bank), 1);

    // Backpressure: no retirements, depth 2
    echo_en = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_time", 32'(time_count), 0);
    chk("restart_finished", 32'(finished), 0);
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (rd_valid && rd_ready) cnt++;
      @(negedge clk);
    end
    chk("bp_two_xfers", 32'(cnt), 2);
    chk("bp_valid_low", 32'(rd_valid), 0);
    chk("bp_addr", 32'(rd_addr), 2);
    man_wr = 1'b1;
    @(negedge clk);
    man_wr = 1'b0;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (rd_valid && rd_ready) cnt++;
      @(negedge clk);
    end
    chk("bp_one_more", 32'(cnt), 1);
    chk("bp_addr2", 32'(rd_addr), 3);

    // Transfer and retire in the same cycle
    man_wr = 1'b1;
    @(negedge clk);
    chk("sim_pre_valid", 32'(rd_valid), 1);
    chk("sim_pre_addr", 32'(rd_addr), 3);
    @(negedge clk);
    man_wr = 1'b0;
    chk("sim_valid_kept", 32'(rd_valid), 1);
    chk("sim_addr", 32'(rd_addr), 4);
    @(negedge clk);
    chk("sim_full_valid", 32'(rd_valid), 0);
    chk("sim_full_addr", 32'(rd_addr), 5);

    // Stall at cell (1,1)
    rd_ready = 1'b0;
    man_wr   = 1'b1;
    @(negedge clk);
    man_wr = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", 32'(rd_valid), 1);
      chk("stall_addr", 32'(rd_addr), 5);
      chk("stall_x", 32'(cell_x), 1);
      chk("stall_y", 32'(cell_y), 1);
      chk("stall_bnd", 32'(is_boundary), 1);
      @(negedge clk);
    end
    rd_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_addr", 32'(rd_addr), 6);

    // Reset mid-sweep, then a late retirement
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("reset_mid");
    man_wr = 1'b1;
    @(negedge clk);
    man_wr = 1'b0;
    chk("late_wr_uflow", 32'(err_underflow), 1);
    chk("late_wr_idle", 32'(busy), 0);

    // Step mode
    step_mode = 1'b1;
    echo_en   = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("step_start_uflow", 32'(err_underflow), 0);
    chk("step_start_addr", 32'(rd_addr), 0);
    chk("step_start_bank", 32'(rd_bank), 0);
    for (int c = 0; c < 200; c++) begin
      if (step_done) break;
      @(negedge clk);
    end
    chk("step_swap_seen", 32'(step_done), 1);
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      chk("hold_busy", 32'(busy), 0);
      chk("hold_valid", 32'(rd_valid), 0);
      @(negedge clk);
    end
    chk("hold_time", 32'(time_count), 1);
    chk("hold_bank", 32'(rd_bank), 1);
    chk("hold_not_done", 32'(finished), 0);
    advance = 1'b1;
    @(negedge clk);
    advance = 1'b0;
    chk("adv_valid", 32'(rd_valid), 1);
    chk("adv_addr", 32'(rd_addr), 0);
    chk("adv_bank", 32'(rd_bank), 1);
    chk("adv_busy", 32'(busy), 1);

    // Reset while issuing address 3
    for (int c = 0; c < 100; c++) begin
      if (rd_valid && rd_addr == 3'd3) break;
      @(negedge clk);
    end
    chk("pre_reset_addr", 32'(rd_addr), 3);
    rst     = 1'b1;
    echo_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("reset_at_3");

    step_mode = 1'b0;
    echo_en   = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rs_valid", 32'(rd_valid), 1);
    chk("rs_addr", 32'(rd_addr), 0);
    chk("rs_time", 32'(time_count), 0);
    chk("rs_bank", 32'(rd_bank), 0);
    chk("rs_busy", 32'(busy), 1);
    echo_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
